// File: rtl/lv_owt_tx_ctrl.sv
// lv_owt_tx_ctrl: LV->HV one-wire frame transmitter with CRC8 and response wait.
// crc8_serial: bit-serial CRC8 (x^8+x^2+x+1, init 0, MSB first).
module crc8_serial (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_vld,
   input  logic       i_data,
   input  logic       i_new_calc,
   output logic [7:0] o_crc
);
   logic [7:0] base;
   logic       fb;
   always_comb begin
      base = i_new_calc ? 8'h00 : o_crc;
      fb   = base[7] ^ i_data;
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) o_crc <= 8'h00;
      else if (i_vld) o_crc <= {base[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
endmodule

module lv_owt_tx_ctrl #(
   parameter int OWT_EXT_CYC_NUM  = 8,
   parameter int OWT_SYNC_BIT_NUM = 12,
   parameter int OWT_TAIL_BIT_NUM = 4,
   parameter int OWT_CMD_BIT_NUM  = 8,
   parameter int OWT_DATA_BIT_NUM = 8,
   parameter int OWT_CRC_BIT_NUM  = 8,
   parameter int OWT_RSP_TMO_CYC  = 2048
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_owt_tx_req,
   input  logic [7:0] i_owt_tx_cmd,
   input  logic [7:0] i_owt_tx_data,
   output logic       o_owt_tx_busy,
   output logic       o_owt_tx_ack,
   output logic       o_owt_rsp_tmo,
   output logic [7:0] o_owt_tx_cmd_lock,
   input  logic       i_owt_rx_ack,
   output logic       o_lv_hv_owt_tx
);
   localparam int TW = ($clog2(OWT_RSP_TMO_CYC) > 12) ? $clog2(OWT_RSP_TMO_CYC) : 12;
   localparam int CW = (OWT_EXT_CYC_NUM > 1) ? $clog2(OWT_EXT_CYC_NUM) : 1;

   typedef enum logic [2:0] {S_IDLE, S_HEAD, S_STAIL, S_CMD, S_DATA, S_CRC, S_ETAIL, S_WAIT} state_t;

   state_t        state, state_d;
   logic [CW-1:0] chip, chip_d;
   logic [7:0]    idx, idx_d, len;
   logic [TW-1:0] tmo_cnt;
   logic [7:0]    data_q, crc_q, crc_out, cbyte, fbyte, fsh, csh;
   logic          wrap, last, in_frame, accept, tmo_hit, rsp_done, line_d, crc_vld, crc_new;

   always_comb begin
      len = (state == S_HEAD) ? 8'(2 * OWT_SYNC_BIT_NUM) :
            (state == S_STAIL || state == S_ETAIL) ? 8'(OWT_TAIL_BIT_NUM) :
            (state == S_CMD) ? 8'(2 * OWT_CMD_BIT_NUM) :
            (state == S_DATA) ? 8'(2 * OWT_DATA_BIT_NUM) : 8'(2 * OWT_CRC_BIT_NUM);
      in_frame = state != S_IDLE && state != S_WAIT;
      wrap     = chip == CW'(OWT_EXT_CYC_NUM - 1);
      last     = in_frame && wrap && idx == len - 8'd1;
      accept   = state == S_IDLE && i_owt_tx_req;
      tmo_hit  = tmo_cnt == TW'(OWT_RSP_TMO_CYC - 1);
      rsp_done = state == S_WAIT && (i_owt_rx_ack || tmo_hit);
      state_d  = accept ? S_HEAD : rsp_done ? S_IDLE : last ? state_t'(state + 3'd1) : state;
      chip_d   = (!in_frame || wrap) ? '0 : chip + 1'b1;
      idx_d    = (!in_frame || last) ? 8'h00 : idx + 8'(wrap);
      // Line is registered from next-state values so it changes exactly at chip boundaries.
      cbyte    = (state == S_CRC) ? crc_q : crc_out;
      fbyte    = (state_d == S_CMD) ? o_owt_tx_cmd_lock : (state_d == S_DATA) ? data_q :
                 (state_d == S_CRC) ? cbyte : 8'h00;
      fsh      = fbyte << idx_d[3:1];
      line_d   = (state_d == S_STAIL || state_d == S_ETAIL) ? (idx_d < 8'(OWT_TAIL_BIT_NUM / 2)) :
                 (state_d inside {S_HEAD, S_CMD, S_DATA, S_CRC}) ? fsh[7] ^ idx_d[0] : 1'b0;
      csh      = ((state == S_CMD) ? o_owt_tx_cmd_lock : data_q) << idx[3:1];
      crc_vld  = (state == S_CMD || state == S_DATA) && !idx[0] && chip == '0;
      crc_new  = crc_vld && state == S_CMD && idx == 8'h00;
   end

   crc8_serial u_crc (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_vld      (crc_vld),
      .i_data     (csh[7]),
      .i_new_calc (crc_new),
      .o_crc      (crc_out)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state             <= S_IDLE;
         chip              <= '0;
         idx               <= 8'h00;
         tmo_cnt           <= '0;
         data_q            <= 8'h00;
         crc_q             <= 8'h00;
         o_owt_tx_cmd_lock <= 8'h00;
         o_lv_hv_owt_tx    <= 1'b0;
         o_owt_tx_ack      <= 1'b0;
         o_owt_rsp_tmo     <= 1'b0;
         o_owt_tx_busy     <= 1'b0;
      end else begin
         state          <= state_d;
         chip           <= chip_d;
         idx            <= idx_d;
         tmo_cnt        <= (state == S_WAIT) ? tmo_cnt + 1'b1 : '0;
         if (accept) begin
            o_owt_tx_cmd_lock <= i_owt_tx_cmd;
            data_q            <= i_owt_tx_data;
         end
         if (state == S_DATA && state_d == S_CRC) crc_q <= crc_out;
         o_lv_hv_owt_tx <= line_d;
         o_owt_tx_ack   <= rsp_done;
         o_owt_rsp_tmo  <= rsp_done && !i_owt_rx_ack;
         o_owt_tx_busy  <= state_d != S_IDLE || rsp_done;
      end
   end
endmodule

// File: tb/tb_lv_owt_tx_ctrl.sv
// tb_lv_owt_tx_ctrl: directed + randomized frame checks against a chip-level reference model.
module tb_lv_owt_tx_ctrl;
   logic       clk = 1'b0, rst_n = 1'b0, req = 1'b0, rx_ack = 1'b0;
   logic [7:0] cmd = 8'h00, data = 8'h00, cmd_lock;
   logic       busy, ack, tmo, line;
   int         checks = 0, errors = 0;

   always #5 clk = ~clk;

   lv_owt_tx_ctrl dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_owt_tx_req      (req),
      .i_owt_tx_cmd      (cmd),
      .i_owt_tx_data     (data),
      .o_owt_tx_busy     (busy),
      .o_owt_tx_ack      (ack),
      .o_owt_rsp_tmo     (tmo),
      .o_owt_tx_cmd_lock (cmd_lock),
      .i_owt_rx_ack      (rx_ack),
      .o_lv_hv_owt_tx    (line)
   );

   // CRC8 as polynomial remainder of msg*x^8 mod x^8+x^2+x+1.
   function automatic logic [7:0] crc8_ref(input logic [15:0] m);
      logic [23:0] r;
      r = {m, 8'h00};
      for (int i = 23; i >= 8; i--) if (r[i]) r = r ^ (24'h107 << (i - 8));
      return r[7:0];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Accept a request, then check every cycle of the 640-cycle frame; returns at WAIT_RSP entry.
   task automatic frame(input logic [7:0] c, input logic [7:0] d, input bit noise, input bit hold);
      logic        exp[$];
      logic [23:0] f;
      f = {c, d, crc8_ref({c, d})};
      exp = {};
      for (int i = 0; i < 12; i++) begin exp.push_back(1'b0); exp.push_back(1'b1); end
      exp.push_back(1'b1); exp.push_back(1'b1); exp.push_back(1'b0); exp.push_back(1'b0);
      for (int i = 23; i >= 0; i--) begin exp.push_back(f[i]); exp.push_back(!f[i]); end
      exp.push_back(1'b1); exp.push_back(1'b1); exp.push_back(1'b0); exp.push_back(1'b0);
      cmd = c; data = d; req = 1'b1;
      tick;
      req = hold;
      chk("lock_at_accept", cmd_lock, c);
      chk("busy_at_accept", busy, 1);
      for (int i = 0; i < 640; i++) begin
         chk("line", line, exp[i / 8]);
         chk("ack_in_frame", ack, 0);
         if (noise) begin
            req = 1'($urandom); rx_ack = ($urandom_range(0, 5) == 0);
            cmd = 8'($urandom); data = 8'($urandom);
         end
         tick;
      end
      req = hold; rx_ack = 1'b0;
      chk("lock_hold", cmd_lock, c);
      chk("line_wait", line, 0);
      chk("busy_wait", busy, 1);
      chk("ack_wait", ack, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, observed running expected finished");
      $fatal(1);
   end

   initial begin
      logic [7:0] c1, c2;
      tick; tick;
      chk("rst_line", line, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ack", ack, 0);
      chk("rst_tmo", tmo, 0);
      chk("rst_lock", cmd_lock, 8'h00);
      rst_n = 1'b1;
      tick;
      // Write frame, rx ack 10 cycles into WAIT_RSP
      frame(8'h85, 8'h3C, 0, 0);
      repeat (10) tick;
      rx_ack = 1'b1;
      tick;
      rx_ack = 1'b0;
      chk("wr_ack", ack, 1);
      chk("wr_tmo", tmo, 0);
      chk("wr_busy_ack", busy, 1);
      tick;
      chk("wr_ack_pulse", ack, 0);
      chk("wr_busy_after", busy, 0);
      // Read frame with response timeout
      frame(8'h1F, 8'($urandom), 0, 0);
      for (int i = 0; i < 2048; i++) begin
         chk("tmo_early", ack, 0);
         tick;
      end
      chk("tmo_ack", ack, 1);
      chk("tmo_flag", tmo, 1);
      chk("tmo_busy", busy, 1);
      tick;
      chk("tmo_ack_pulse", ack, 0);
      chk("tmo_flag_pulse", tmo, 0);
      chk("tmo_busy_fall", busy, 0);
      // Noisy inputs mid-frame, then rx ack coincident with timeout
      frame(8'($urandom), 8'($urandom), 1, 0);
      repeat (2047) tick;
      rx_ack = 1'b1;
      tick;
      rx_ack = 1'b0;
      chk("sim_ack", ack, 1);
      chk("sim_tmo", tmo, 0);
      tick;
      chk("sim_no_extra_ack", ack, 0);
      chk("sim_busy_fall", busy, 0);
      // Random frames with random response delay
      for (int n = 0; n < 2; n++) begin
         int k;
         frame(8'($urandom), 8'($urandom), 0, 0);
         k = $urandom_range(0, 300);
         repeat (k) begin chk("rnd_early", ack, 0); tick; end
         rx_ack = 1'b1;
         tick;
         rx_ack = 1'b0;
         chk("rnd_ack", ack, 1);
         chk("rnd_tmo", tmo, 0);
         tick;
      end
      // Reset in the CRC field
      cmd = 8'hA7; data = 8'h5E; req = 1'b1;
      tick;
      req = 1'b0;
      repeat (500) tick;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_line", line, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ack", ack, 0);
      chk("mid_rst_tmo", tmo, 0);
      chk("mid_rst_lock", cmd_lock, 8'h00);
      tick;
      rst_n = 1'b1;
      tick;
      chk("post_rst_ack", ack, 0);
      frame(8'($urandom), 8'($urandom), 0, 0);
      rx_ack = 1'b1;
      tick;
      rx_ack = 1'b0;
      chk("post_rst_frame_ack", ack, 1);
      tick;
      // Back-to-back with request held through ack
      c1 = 8'($urandom); c2 = ~c1;
      frame(c1, 8'($urandom), 0, 1);
      repeat (5) tick;
      rx_ack = 1'b1;
      tick;
      rx_ack = 1'b0;
      chk("b2b_ack1", ack, 1);
      chk("b2b_lock1", cmd_lock, c1);
      frame(c2, 8'($urandom), 0, 0);
      rx_ack = 1'b1;
      tick;
      rx_ack = 1'b0;
      chk("b2b_ack2", ack, 1);
      tick;
      chk("b2b_busy_end", busy, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
